// File: rtl/alu_pipe_if.sv
// Request/result bus of the pipelined ALU.
// The requester drives the operation and consumes the result through the master modport.
// The ALU sits on the slave modport.
interface alu_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       opcode;
  logic [3:0]       cc;
  logic [WIDTH-1:0] a_data;
  logic [WIDTH-1:0] b_data;
  logic             carry_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] z_data;
  logic             carry_out;
  logic             zero;
  logic             negative;
  logic             overflow;
  logic             busy;

  modport master (
    output in_valid, opcode, cc, a_data, b_data, carry_in, out_ready,
    input  in_ready, out_valid, z_data, carry_out, zero, negative, overflow, busy
  );

  modport slave (
    input  in_valid, opcode, cc, a_data, b_data, carry_in, out_ready,
    output in_ready, out_valid, z_data, carry_out, zero, negative, overflow, busy
  );
endinterface

// File: rtl/alu_pipe.sv
// Pipelined ALU with a valid/ready request and result handshake.
// Single-cycle operations register their result at the accept edge.
// MPY runs an iterative shift-add over WIDTH cycles.
// The result and flags are held until the consumer takes them.
module alu_pipe #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input logic       clk,
  input logic       rst_n,
  alu_pipe_if.slave bus
);
  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_MPY  = 5'd2;
  localparam logic [4:0] OP_AND  = 5'd3;
  localparam logic [4:0] OP_OR   = 5'd4;
  localparam logic [4:0] OP_XOR  = 5'd5;
  localparam logic [4:0] OP_SHL  = 5'd6;
  localparam logic [4:0] OP_SRL  = 5'd7;
  localparam logic [4:0] OP_SRA  = 5'd8;
  localparam logic [4:0] OP_MOV  = 5'd9;
  localparam logic [4:0] OP_MOVH = 5'd10;
  localparam logic [4:0] OP_CMP  = 5'd11;
  localparam logic [4:0] OP_ADDC = 5'd12;
  localparam logic [4:0] OP_SUBB = 5'd13;

  localparam logic [3:0] CC_EQ  = 4'd0;
  localparam logic [3:0] CC_NE  = 4'd1;
  localparam logic [3:0] CC_LT  = 4'd2;
  localparam logic [3:0] CC_LE  = 4'd3;
  localparam logic [3:0] CC_ULT = 4'd4;
  localparam logic [3:0] CC_ULE = 4'd5;
  localparam logic [3:0] CC_GE  = 4'd6;
  localparam logic [3:0] CC_GT  = 4'd7;
  localparam logic [3:0] CC_UGE = 4'd8;
  localparam logic [3:0] CC_UGT = 4'd9;

  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, MUL, RESULT} state_t;

  state_t           state_reg, state_next;
  logic             accept, is_mpy;
  logic [WIDTH-1:0] z_reg, alu_z;
  logic             carry_reg, zero_reg, neg_reg, ovf_reg;
  logic             alu_c, alu_v, cmp_res;
  logic [WIDTH-1:0] acc_reg, acc_next, mcand_reg, mplier_reg;
  logic [SHW-1:0]   cnt_reg, shamt;
  logic [WIDTH:0]   add_full, sub_full;
  logic             add_cin, sub_bin;

  assign bus.in_ready  = (state_reg == IDLE) || (state_reg == RESULT && bus.out_ready);
  assign bus.out_valid = (state_reg == RESULT);
  assign bus.busy      = (state_reg == MUL);
  assign bus.z_data    = z_reg;
  assign bus.carry_out = carry_reg;
  assign bus.zero      = zero_reg;
  assign bus.negative  = neg_reg;
  assign bus.overflow  = ovf_reg;

  assign accept = bus.in_valid && bus.in_ready;
  assign is_mpy = (bus.opcode == OP_MPY);
  assign shamt  = bus.b_data[SHW-1:0];

  // Extended add/subtract: the extra top bit yields the carry and the borrow.
  assign add_cin  = (bus.opcode == OP_ADDC) && bus.carry_in;
  assign sub_bin  = (bus.opcode == OP_SUBB) && bus.carry_in;
  assign add_full = {1'b0, bus.a_data} + {1'b0, bus.b_data} + {{WIDTH{1'b0}}, add_cin};
  assign sub_full = {1'b0, bus.a_data} - {1'b0, bus.b_data} - {{WIDTH{1'b0}}, sub_bin};

  // One shift-add step: add the multiplicand when the current multiplier bit is set.
  assign acc_next = acc_reg + (mplier_reg[0] ? mcand_reg : {WIDTH{1'b0}});

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic.
  // A new accept in RESULT takes priority over returning to IDLE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = is_mpy ? MUL : RESULT;
      MUL:     if (cnt_reg == CNT_LAST) state_next = RESULT;
      RESULT: begin
        if (accept)             state_next = is_mpy ? MUL : RESULT;
        else if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Condition evaluation for CMP.
  // An undefined condition code evaluates false.
  always_comb begin
    cmp_res = 1'b0;
    case (bus.cc)
      CC_EQ:   cmp_res = (bus.a_data == bus.b_data);
      CC_NE:   cmp_res = (bus.a_data != bus.b_data);
      CC_LT:   cmp_res = ($signed(bus.a_data) <  $signed(bus.b_data));
      CC_LE:   cmp_res = ($signed(bus.a_data) <= $signed(bus.b_data));
      CC_ULT:  cmp_res = (bus.a_data <  bus.b_data);
      CC_ULE:  cmp_res = (bus.a_data <= bus.b_data);
      CC_GE:   cmp_res = ($signed(bus.a_data) >= $signed(bus.b_data));
      CC_GT:   cmp_res = ($signed(bus.a_data) >  $signed(bus.b_data));
      CC_UGE:  cmp_res = (bus.a_data >= bus.b_data);
      CC_UGT:  cmp_res = (bus.a_data >  bus.b_data);
      default: cmp_res = 1'b0;
    endcase
  end

  // Single-cycle result and carry/overflow.
  // Undefined opcodes produce zero.
  always_comb begin
    alu_z = {WIDTH{1'b0}};
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (bus.opcode)
      OP_ADD, OP_ADDC: begin
        alu_z = add_full[WIDTH-1:0];
        alu_c = add_full[WIDTH];
        alu_v = (bus.a_data[WIDTH-1] == bus.b_data[WIDTH-1]) &&
                (add_full[WIDTH-1] != bus.a_data[WIDTH-1]);
      end
      OP_SUB, OP_SUBB: begin
        alu_z = sub_full[WIDTH-1:0];
        alu_c = sub_full[WIDTH];
        alu_v = (bus.a_data[WIDTH-1] != bus.b_data[WIDTH-1]) &&
                (sub_full[WIDTH-1] != bus.a_data[WIDTH-1]);
      end
      OP_AND:  alu_z = bus.a_data & bus.b_data;
      OP_OR:   alu_z = bus.a_data | bus.b_data;
      OP_XOR:  alu_z = bus.a_data ^ bus.b_data;
      OP_SHL:  alu_z = bus.a_data << shamt;
      OP_SRL:  alu_z = bus.a_data >> shamt;
      OP_SRA:  alu_z = $signed(bus.a_data) >>> shamt;
      OP_MOV:  alu_z = bus.a_data;
      OP_MOVH: alu_z = {bus.a_data[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      OP_CMP:  alu_z = {{(WIDTH-1){1'b0}}, cmp_res};
      default: alu_z = {WIDTH{1'b0}};
    endcase
  end

  // Operand capture, the multiply iteration and the result/flag registers.
  // The result and flags change only on an accept or on the final multiply step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_reg      <= '0;
      carry_reg  <= 1'b0;
      zero_reg   <= 1'b0;
      neg_reg    <= 1'b0;
      ovf_reg    <= 1'b0;
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      cnt_reg    <= '0;
    end else if (accept && is_mpy) begin
      acc_reg    <= '0;
      mcand_reg  <= bus.a_data;
      mplier_reg <= bus.b_data;
      cnt_reg    <= '0;
    end else if (accept) begin
      z_reg     <= alu_z;
      carry_reg <= alu_c;
      ovf_reg   <= alu_v;
      zero_reg  <= (alu_z == {WIDTH{1'b0}});
      neg_reg   <= alu_z[WIDTH-1];
    end else if (state_reg == MUL) begin
      acc_reg    <= acc_next;
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
      cnt_reg    <= cnt_reg + 1'b1;
      if (cnt_reg == CNT_LAST) begin
        z_reg     <= acc_next;
        carry_reg <= 1'b0;
        ovf_reg   <= 1'b0;
        zero_reg  <= (acc_next == {WIDTH{1'b0}});
        neg_reg   <= acc_next[WIDTH-1];
      end
    end
  end
endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe.
// Expected results come from an arithmetic reference model.
module tb_alu_pipe;
  localparam int W = 32;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_MPY  = 5'd2;
  localparam logic [4:0] OP_AND  = 5'd3;
  localparam logic [4:0] OP_OR   = 5'd4;
  localparam logic [4:0] OP_XOR  = 5'd5;
  localparam logic [4:0] OP_SHL  = 5'd6;
  localparam logic [4:0] OP_SRL  = 5'd7;
  localparam logic [4:0] OP_SRA  = 5'd8;
  localparam logic [4:0] OP_MOV  = 5'd9;
  localparam logic [4:0] OP_MOVH = 5'd10;
  localparam logic [4:0] OP_CMP  = 5'd11;
  localparam logic [4:0] OP_ADDC = 5'd12;
  localparam logic [4:0] OP_SUBB = 5'd13;

  localparam longint MAXS = 64'sh7FFF_FFFF;
  localparam longint MINS = -64'sh8000_0000;

  typedef struct packed {
    logic [31:0] z;
    logic        c;
    logic        zf;
    logic        n;
    logic        v;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  alu_pipe_if #(.WIDTH(W)) bus ();

  alu_pipe #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // Reference model: plain wide integer arithmetic.
  function automatic res_t model(input logic [4:0] op, input logic [3:0] c,
                                 input logic [31:0] a, input logic [31:0] b, input logic ci);
    res_t r;
    longint sa, sb, st;
    longint unsigned ua, ub, ut, k;
    logic cond;
    logic [31:0] z;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    z = 32'd0;
    r.c = 1'b0;
    r.v = 1'b0;
    case (op)
      OP_ADD, OP_ADDC: begin
        k = (op == OP_ADDC && ci) ? 64'd1 : 64'd0;
        ut = ua + ub + k;
        z = ut[31:0];
        r.c = ut[32];
        st = sa + sb + longint'(k);
        r.v = (st > MAXS) || (st < MINS);
      end
      OP_SUB, OP_SUBB: begin
        k = (op == OP_SUBB && ci) ? 64'd1 : 64'd0;
        ut = ua - ub - k;
        z = ut[31:0];
        r.c = (ua < ub + k);
        st = sa - sb - longint'(k);
        r.v = (st > MAXS) || (st < MINS);
      end
      OP_MPY: begin
        ut = ua * ub;
        z = ut[31:0];
      end
      OP_AND:  z = a & b;
      OP_OR:   z = a | b;
      OP_XOR:  z = a ^ b;
      OP_SHL:  z = a << b[4:0];
      OP_SRL:  z = a >> b[4:0];
      OP_SRA: begin
        st = sa >>> b[4:0];
        z = st[31:0];
      end
      OP_MOV:  z = a;
      OP_MOVH: z = 32'(ua * 64'd65536);
      OP_CMP: begin
        case (c)
          4'd0:    cond = (sa == sb);
          4'd1:    cond = (sa != sb);
          4'd2:    cond = (sa <  sb);
          4'd3:    cond = (sa <= sb);
          4'd4:    cond = (ua <  ub);
          4'd5:    cond = (ua <= ub);
          4'd6:    cond = (sa >= sb);
          4'd7:    cond = (sa >  sb);
          4'd8:    cond = (ua >= ub);
          4'd9:    cond = (ua >  ub);
          default: cond = 1'b0;
        endcase
        z = {31'd0, cond};
      end
      default: z = 32'd0;
    endcase
    r.z  = z;
    r.zf = (z == 32'd0);
    r.n  = z[31];
    return r;
  endfunction

  function automatic res_t obs();
    return {bus.z_data, bus.carry_out, bus.zero, bus.negative, bus.overflow};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      4:       return 32'($urandom_range(0, 40));
      default: return 32'($urandom);
    endcase
  endfunction

  // One complete transaction from IDLE.
  // Checks latency and result, then consumes it.
  task automatic run_op(input string tag, input logic [4:0] op, input logic [3:0] c,
                        input logic [31:0] a, input logic [31:0] b, input logic ci,
                        output res_t got);
    res_t e;
    int lat, busy_n, rdy_n;
    e = model(op, c, a, b, ci);
    check({tag, "_rdy"}, 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.opcode = op;
    bus.cc = c;
    bus.a_data = a;
    bus.b_data = b;
    bus.carry_in = ci;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.opcode = 5'($urandom);
    bus.cc = 4'($urandom);
    bus.a_data = 32'($urandom);
    bus.b_data = 32'($urandom);
    bus.carry_in = 1'($urandom);
    lat = 1;
    busy_n = 0;
    rdy_n = 0;
    while (!bus.out_valid && lat < 100) begin
      if (bus.busy) busy_n++;
      if (bus.in_ready) rdy_n++;
      @(posedge clk); #1;
      lat++;
    end
    got = obs();
    $display("op %-10s opc=%0d cc=%0d a=%h b=%h ci=%0d -> z=%h c=%0d zf=%0d n=%0d v=%0d lat=%0d",
             tag, op, c, a, b, ci, got.z, got.c, got.zf, got.n, got.v, lat);
    check({tag, "_lat"}, 64'(lat), 64'((op == OP_MPY) ? 33 : 1));
    if (op == OP_MPY) begin
      check({tag, "_busy"}, 64'(busy_n), 64'd32);
      check({tag, "_rdylow"}, 64'(rdy_n), 64'd0);
    end
    check({tag, "_res"}, 64'(got), 64'(e));
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({tag, "_drop"}, 64'(bus.out_valid), 64'd0);
  endtask

  initial begin
    res_t got, e;
    int ov_n;
    logic [4:0] op;

    bus.in_valid = 1'b0;
    bus.opcode = 5'd0;
    bus.cc = 4'd0;
    bus.a_data = 32'd0;
    bus.b_data = 32'd0;
    bus.carry_in = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    #1;
    check("rst_ov", 64'(bus.out_valid), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_res", 64'(obs()), 64'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_rdy", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;

    // Directed corner cases
    run_op("add_wrap", OP_ADD, 4'd0, 32'hFFFF_FFFF, 32'd1, 1'b0, got);
    check("add_wrap_k", 64'(got), 64'({32'h0, 1'b1, 1'b1, 1'b0, 1'b0}));
    run_op("subb_ovf", OP_SUBB, 4'd0, 32'h8000_0000, 32'd0, 1'b1, got);
    check("subb_ovf_k", 64'(got), 64'({32'h7FFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1}));
    run_op("mpy", OP_MPY, 4'd0, 32'h0001_0001, 32'h0001_0001, 1'b0, got);
    check("mpy_k", 64'(got), 64'({32'h0002_0001, 1'b0, 1'b0, 1'b0, 1'b0}));
    run_op("cmp_ult", OP_CMP, 4'd4, 32'd1, 32'hFFFF_FFFF, 1'b0, got);
    check("cmp_ult_k", 64'(got.z), 64'd1);
    run_op("cmp_lt", OP_CMP, 4'd2, 32'd1, 32'hFFFF_FFFF, 1'b0, got);
    check("cmp_lt_k", 64'(got.z), 64'd0);
    run_op("sra", OP_SRA, 4'd0, 32'h8000_0000, 32'h24, 1'b0, got);
    check("sra_k", 64'(got.z), 64'h0000_0000_F800_0000);
    run_op("undef", 5'd20, 4'd0, 32'h1234_5678, 32'h9, 1'b1, got);
    check("undef_k", 64'(got), 64'({32'h0, 1'b0, 1'b1, 1'b0, 1'b0}));

    // Back-pressure: XOR result held for 5 cycles while an ADD waits.
    bus.in_valid = 1'b1;
    bus.opcode = OP_XOR;
    bus.a_data = 32'hA5A5_F00F;
    bus.b_data = 32'h0FF0_0FF0;
    bus.out_ready = 1'b0;
    e = model(OP_XOR, 4'd0, 32'hA5A5_F00F, 32'h0FF0_0FF0, 1'b0);
    @(posedge clk); #1;
    check("bp_first", 64'(obs()), 64'(e));
    bus.opcode = OP_ADD;
    bus.a_data = 32'h7FFF_FFFF;
    bus.b_data = 32'h0000_0001;
    bus.carry_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_hold", 64'(obs()), 64'(e));
      check("bp_rdy", 64'(bus.in_ready), 64'd0);
      check("bp_ov", 64'(bus.out_valid), 64'd1);
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp_rdy_up", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("bp_nogap_ov", 64'(bus.out_valid), 64'd1);
    check("bp_nogap_res", 64'(obs()), 64'({32'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b1}));
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("bp_drop", 64'(bus.out_valid), 64'd0);

    // Reset in cycle 10 of a multiply.
    bus.in_valid = 1'b1;
    bus.opcode = OP_MPY;
    bus.a_data = 32'd3;
    bus.b_data = 32'd5;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("rmul_busy", 64'(bus.busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rmul_ov", 64'(bus.out_valid), 64'd0);
    check("rmul_busy0", 64'(bus.busy), 64'd0);
    check("rmul_res", 64'(obs()), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("rmul_rdy", 64'(bus.in_ready), 64'd1);
    ov_n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) ov_n++;
    end
    check("rmul_noval", 64'(ov_n), 64'd0);

    // Streaming: one single-cycle operation per clock with out_ready held high.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      do op = 5'($urandom_range(0, 13)); while (op == OP_MPY);
      bus.in_valid = 1'b1;
      bus.opcode = op;
      bus.cc = 4'($urandom_range(0, 9));
      bus.a_data = pick();
      bus.b_data = pick();
      bus.carry_in = 1'($urandom);
      e = model(op, bus.cc, bus.a_data, bus.b_data, bus.carry_in);
      #1;
      check("stream_rdy", 64'(bus.in_ready), 64'd1);
      @(posedge clk); #1;
      $display("stream opc=%0d -> z=%h", op, bus.z_data);
      check("stream_ov", 64'(bus.out_valid), 64'd1);
      check("stream_res", 64'(obs()), 64'(e));
    end
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("stream_drop", 64'(bus.out_valid), 64'd0);

    // Randomized operations, including MPY and undefined opcodes.
    for (int i = 0; i < 150; i++) begin
      op = 5'($urandom_range(0, 16));
      if (op == 5'd16) op = 5'd31;
      run_op("rand", op, 4'($urandom), pick(), pick(), 1'($urandom), got);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32: datapath width; legal values are powers of two, 16 to 64.
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH): number of shift-amount bits.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: operation request.
REQ-006 SHALL have port in_ready, output, 1 bit: request accepted when in_valid and in_ready are both high at a clock edge.
REQ-007 SHALL have port opcode, input, 5 bits: encodings from defines.vh (ADD, SUB, MPY, AND, OR, XOR, SHL, SRL, SRA, MOV, MOVH, CMP), plus new codes ADDC and SUBB added to defines.vh.
REQ-008 SHALL have port cc, input, 4 bits: CMP condition (EQ, NE, LT, LE, ULT, ULE, GE, GT, UGE, UGT).
REQ-009 SHALL have ports a_data and b_data, input, WIDTH bits each: operands.
REQ-010 SHALL have port carry_in, input, 1 bit: carry/borrow input for ADDC and SUBB.
REQ-011 SHALL have port out_valid, output, 1 bit: a result is held on the outputs.
REQ-012 SHALL have port out_ready, input, 1 bit: result consumed when out_valid and out_ready are both high at a clock edge.
REQ-013 SHALL have port z_data, output, WIDTH bits: registered result.
REQ-014 SHALL have ports carry_out, zero, negative and overflow, output, 1 bit each: registered flags.
REQ-015 SHALL have port busy, output, 1 bit: high while the state machine is in MUL.

Function
REQ-016 SHALL sample opcode, cc, a_data, b_data and carry_in only on an accepted request; inputs presented while in_ready is low SHALL be ignored.
REQ-017 SHALL implement a three-state FSM with states IDLE, MUL and RESULT.
REQ-018 SHALL, on an accept of any non-MPY operation, move to RESULT and register the result and flags at that same edge (latency 1, out_valid high in the following cycle).
REQ-019 SHALL, on an accept of MPY, move to MUL and run an iterative shift-add of WIDTH cycles, then move to RESULT; out_valid SHALL be high WIDTH+1 edges after the accept.
REQ-020 SHALL drive in_ready = (state==IDLE) or (state==RESULT and out_ready), giving throughput of one operation per cycle for non-MPY operations under continuous out_ready.
REQ-021 SHALL, in RESULT, hold z_data and all flags stable until consumed; on consume without a new accept it SHALL return to IDLE and drop out_valid.
REQ-022 SHALL, when a consume and a new accept occur at the same edge, load the new result (non-MPY, staying in RESULT) or enter MUL (MPY, out_valid low).
REQ-023 SHALL compute ADD, SUB, AND, OR, XOR and MOV modulo 2^WIDTH.
REQ-024 SHALL compute MPY as the low WIDTH bits of the product.
REQ-025 SHALL compute MOVH as {a_data[WIDTH/2-1:0], WIDTH/2 zeros}.
REQ-026 SHALL compute SHL, SRL and SRA using shift amount b_data[SHW-1:0]; SRA is arithmetic.
REQ-027 SHALL compute CMP as z_data[0] = condition result and all upper bits 0; an undefined cc yields 0.
REQ-028 SHALL compute ADDC as a+b+carry_in and SUBB as a-b-carry_in.
REQ-029 SHALL set carry_out to bit WIDTH of the sum for ADD/ADDC, and to the borrow (unsigned underflow) for SUB/SUBB; carry_out = 0 for all other operations.
REQ-030 SHALL set overflow to signed two's-complement overflow for ADD/ADDC/SUB/SUBB; overflow = 0 otherwise.
REQ-031 SHALL set zero = (z_data==0) and negative = z_data[WIDTH-1] for every operation.
REQ-032 SHALL give an undefined opcode z_data = 0, zero = 1 and all other flags 0, with latency 1.

Reset
REQ-033 SHALL, when rst_n is low, immediately force state IDLE, out_valid 0, busy 0, z_data 0 and all flags 0.
REQ-034 SHALL drive in_ready 1 in the first cycle after reset deassertion.
REQ-035 SHALL, if reset asserts mid-MUL or while a result is held, discard the operation; no out_valid SHALL follow reset release.

Verification
REQ-036 SHALL cover ADD, WIDTH=32: a=0xFFFFFFFF, b=1 -> z=0, carry_out=1, zero=1, overflow=0, out_valid one cycle after accept.
REQ-037 SHALL cover SUBB: a=0x80000000, b=0, carry_in=1 -> z=0x7FFFFFFF, overflow=1, carry_out=0, negative=0.
REQ-038 SHALL cover MPY: a=0x00010001, b=0x00010001 -> z=0x00020001, busy high 32 cycles, out_valid at edge 33 after accept, in_ready low throughout.
REQ-039 SHALL cover back-pressure: out_ready held low 5 cycles after an XOR result -> z_data stable, in_ready low; out_ready high with a new ADD accepted the same cycle -> new result the next cycle, no gap.
REQ-040 SHALL cover reset mid-MUL: rst_n pulsed low at cycle 10 of MPY -> all outputs 0 immediately, in_ready=1 after release, no spurious out_valid.
REQ-041 SHALL cover CMP and SRA: CMP ULT a=1, b=0xFFFFFFFF -> z=1; CMP LT same operands -> z=0; SRA a=0x80000000, b=0x24 -> z=0xF8000000 (shift amount 4).
